// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
//   Turns the clock generator's lock indication into staged, glitch-free
//   active-low resets for the NPU. The peripheral/AXI reset releases first and
//   the compute-core reset follows a fixed number of cycles later. Lock loss
//   re-asserts everything and is recorded in a sticky flag and a saturating
//   counter. Software can pulse a core-only reset while running.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   locked_in      clock generator lock, asynchronous to clk
//   sw_rst_req     software core-reset request (single-cycle pulse, RUN only)
//   clr_lost       clears lock_lost and lock_loss_cnt
//   periph_rst_n   peripheral reset, active low, registered
//   core_rst_n     core reset, active low, registered
//   sys_ready      both resets released and system running, registered
//   lock_lost      sticky lock-loss flag
//   lock_loss_cnt  saturating lock-loss event count
//
// State       | meaning
// ------------+------------------------------------------------------------
// IDLE        | all resets asserted, qualifying lock stability
// REL_PERIPH  | peripheral reset released, timing the stage delay to core
// RUN         | all resets released, sys_ready high
// SW_HOLD     | core held in reset on software request, peripherals running

module clk_rst_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 16,
   parameter int STAGE_DELAY        = 8,
   parameter int SW_RST_CYCLES      = 4,
   parameter int CNT_W              = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             locked_in,
   input  logic             sw_rst_req,
   input  logic             clr_lost,
   output logic             periph_rst_n,
   output logic             core_rst_n,
   output logic             sys_ready,
   output logic             lock_lost,
   output logic [CNT_W-1:0] lock_loss_cnt
);

   localparam int STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int DLY_MAX = (STAGE_DELAY > SW_RST_CYCLES) ? STAGE_DELAY : SW_RST_CYCLES;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REL_PERIPH = 2'd1,
      RUN        = 2'd2,
      SW_HOLD    = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;

   state_t             state_q, state_d;
   logic [STAB_W-1:0]  stab_q, stab_d;
   logic [DLY_W-1:0]   dly_q, dly_d;
   logic               periph_d, core_d, ready_d, lost_d;
   logic [CNT_W-1:0]   cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         stab_q        <= '0;
         dly_q         <= '0;
         periph_rst_n  <= 1'b0;
         core_rst_n    <= 1'b0;
         sys_ready     <= 1'b0;
         lock_lost     <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         state_q       <= state_d;
         stab_q        <= stab_d;
         dly_q         <= dly_d;
         periph_rst_n  <= periph_d;
         core_rst_n    <= core_d;
         sys_ready     <= ready_d;
         lock_lost     <= lost_d;
         lock_loss_cnt <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stab_d   = stab_q;
      dly_d    = dly_q;
      periph_d = periph_rst_n;
      core_d   = core_rst_n;
      ready_d  = sys_ready;
      lost_d   = lock_lost;
      cnt_d    = lock_loss_cnt;

      if (clr_lost) begin
         lost_d = 1'b0;
         cnt_d  = '0;
      end

      case (state_q)
         IDLE: begin
            periph_d = 1'b0;
            core_d   = 1'b0;
            ready_d  = 1'b0;
            if (locked_s) begin
               if (stab_q == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
                  state_d  = REL_PERIPH;
                  periph_d = 1'b1;
                  stab_d   = '0;
                  dly_d    = DLY_W'(STAGE_DELAY - 1);
               end else begin
                  stab_d = stab_q + STAB_W'(1);
               end
            end else begin
               stab_d = '0;
            end
         end
         REL_PERIPH: begin
            if (dly_q == '0) begin
               state_d = RUN;
               core_d  = 1'b1;
               ready_d = 1'b1;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         RUN: begin
            if (sw_rst_req) begin
               state_d = SW_HOLD;
               core_d  = 1'b0;
               ready_d = 1'b0;
               dly_d   = DLY_W'(SW_RST_CYCLES - 1);
            end
         end
         SW_HOLD: begin
            // Requests arriving here are ignored; the hold timer never reloads.
            if (dly_q == '0) begin
               state_d = RUN;
               core_d  = 1'b1;
               ready_d = 1'b1;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Lock loss overrides everything above, including sw_rst_req and
      // clr_lost (a coincident clear still leaves a count of one).
      if (state_q != IDLE && !locked_s) begin
         state_d  = IDLE;
         periph_d = 1'b0;
         core_d   = 1'b0;
         ready_d  = 1'b0;
         stab_d   = '0;
         dly_d    = '0;
         lost_d   = 1'b1;
         if (clr_lost)
            cnt_d = CNT_W'(1);
         else if (&lock_loss_cnt)
            cnt_d = lock_loss_cnt;
         else
            cnt_d = lock_loss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Testbench for clk_rst_sequencer: directed stimulus, a cycle-level model of
// the release/loss rules checked on every falling edge, and literal
// expectations at the key edges of each scenario.
module tb_clk_rst_sequencer;

   localparam int SYNC   = 2;
   localparam int STABLE = 16;
   localparam int STAGE  = 8;
   localparam int SWC    = 4;
   localparam int CW     = 2;
   localparam int CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          locked_in = 1'b0;
   logic          sw_rst_req = 1'b0;
   logic          clr_lost = 1'b0;
   logic          periph_rst_n, core_rst_n, sys_ready, lock_lost;
   logic [CW-1:0] lock_loss_cnt;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   clk_rst_sequencer #(
      .SYNC_STAGES       (SYNC),
      .LOCK_STABLE_CYCLES(STABLE),
      .STAGE_DELAY       (STAGE),
      .SW_RST_CYCLES     (SWC),
      .CNT_W             (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .locked_in    (locked_in),
      .sw_rst_req   (sw_rst_req),
      .clr_lost     (clr_lost),
      .periph_rst_n (periph_rst_n),
      .core_rst_n   (core_rst_n),
      .sys_ready    (sys_ready),
      .lock_lost    (lock_lost),
      .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: lock history delay line, run length of qualified-high samples,
   // cycles since peripheral release, and remaining software hold cycles.
   bit pipe [SYNC];
   bit m_periph, m_core, m_lost;
   int m_run, m_since, m_hold, m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
         m_periph = 0; m_core = 0; m_lost = 0;
         m_run = 0; m_since = 0; m_hold = 0; m_cnt = 0;
      end else begin : step
         bit ls;
         ls = pipe[SYNC-1];
         for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = locked_in;
         if (m_periph && !ls) begin
            m_periph = 0; m_core = 0; m_hold = 0; m_since = 0; m_run = 0;
            m_lost = 1;
            m_cnt = clr_lost ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
         end else begin
            if (clr_lost) begin
               m_lost = 0;
               m_cnt = 0;
            end
            if (!m_periph) begin
               if (ls) begin
                  m_run++;
                  if (m_run == STABLE) begin
                     m_periph = 1; m_run = 0; m_since = 0;
                  end
               end else begin
                  m_run = 0;
               end
            end else if (!m_core && m_hold == 0) begin
               m_since++;
               if (m_since == STAGE) m_core = 1;
            end else if (m_hold > 0) begin
               m_hold--;
               if (m_hold == 0) m_core = 1;
            end else if (sw_rst_req) begin
               m_core = 0;
               m_hold = SWC;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model periph_rst_n", 32'(periph_rst_n), 32'(m_periph));
         check("model core_rst_n", 32'(core_rst_n), 32'(m_core));
         check("model sys_ready", 32'(sys_ready), 32'(m_periph && m_core));
         check("model lock_lost", 32'(lock_lost), 32'(m_lost));
         check("model lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_cnt));
      end
   end

   task automatic check_powerup(input string tag);
      tick(17);
      check({tag, " periph e17"}, 32'(periph_rst_n), 0);
      tick(1);
      check({tag, " periph e18"}, 32'(periph_rst_n), 1);
      check({tag, " core e18"}, 32'(core_rst_n), 0);
      tick(7);
      check({tag, " core e25"}, 32'(core_rst_n), 0);
      tick(1);
      check({tag, " core e26"}, 32'(core_rst_n), 1);
      check({tag, " ready e26"}, 32'(sys_ready), 1);
      check({tag, " lost"}, 32'(lock_lost), 0);
      check({tag, " cnt"}, 32'(lock_loss_cnt), 0);
   endtask

   initial begin
      tick(2);
      chk_en = 1'b1;
      check("rst periph", 32'(periph_rst_n), 0);
      check("rst core", 32'(core_rst_n), 0);
      check("rst ready", 32'(sys_ready), 0);
      check("rst lost", 32'(lock_lost), 0);
      check("rst cnt", 32'(lock_loss_cnt), 0);

      // power-up
      rst_n = 1'b1;
      locked_in = 1'b1;
      check_powerup("pu");

      // software reset at edge k, second request at k+2 ignored
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      check("sw core k", 32'(core_rst_n), 0);
      check("sw periph k", 32'(periph_rst_n), 1);
      check("sw ready k", 32'(sys_ready), 0);
      tick(1);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      tick(1);
      check("sw core k+3", 32'(core_rst_n), 0);
      tick(1);
      check("sw core k+4", 32'(core_rst_n), 1);
      check("sw ready k+4", 32'(sys_ready), 1);
      check("sw periph k+4", 32'(periph_rst_n), 1);

      // lock loss in RUN
      locked_in = 1'b0;
      tick(2);
      check("loss ready e2", 32'(sys_ready), 1);
      tick(1);
      check("loss periph", 32'(periph_rst_n), 0);
      check("loss core", 32'(core_rst_n), 0);
      check("loss ready", 32'(sys_ready), 0);
      check("loss lost", 32'(lock_lost), 1);
      check("loss cnt", 32'(lock_loss_cnt), 1);

      // requalification with a one-cycle glitch at stab_cnt=10
      tick(3);
      locked_in = 1'b1;
      tick(12);
      locked_in = 1'b0;
      tick(1);
      locked_in = 1'b1;
      tick(17);
      check("glitch periph +17", 32'(periph_rst_n), 0);
      tick(1);
      check("glitch periph +18", 32'(periph_rst_n), 1);
      tick(7);
      check("glitch core +25", 32'(core_rst_n), 0);
      tick(1);
      check("glitch core +26", 32'(core_rst_n), 1);
      check("glitch ready +26", 32'(sys_ready), 1);

      // four more losses: count saturates at 3
      for (int i = 0; i < 4; i++) begin
         locked_in = 1'b0;
         tick(3);
         check("sat cnt", 32'(lock_loss_cnt), (i + 2 > CMAX) ? CMAX : i + 2);
         check("sat periph", 32'(periph_rst_n), 0);
         locked_in = 1'b1;
         tick(19);
      end
      check("sat final cnt", 32'(lock_loss_cnt), 3);
      check("sat final lost", 32'(lock_lost), 1);

      // clear alone: status clears, resets untouched
      clr_lost = 1'b1;
      tick(1);
      clr_lost = 1'b0;
      check("clr cnt", 32'(lock_loss_cnt), 0);
      check("clr lost", 32'(lock_lost), 0);
      check("clr periph", 32'(periph_rst_n), 1);

      // clear coincident with a loss
      locked_in = 1'b0;
      tick(2);
      clr_lost = 1'b1;
      tick(1);
      clr_lost = 1'b0;
      check("clr+loss cnt", 32'(lock_loss_cnt), 1);
      check("clr+loss lost", 32'(lock_lost), 1);
      check("clr+loss periph", 32'(periph_rst_n), 0);

      // async reset in the middle of SW_HOLD
      locked_in = 1'b1;
      tick(26);
      check("ar ready", 32'(sys_ready), 1);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      check("ar core hold", 32'(core_rst_n), 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar periph", 32'(periph_rst_n), 0);
      check("ar core", 32'(core_rst_n), 0);
      check("ar ready0", 32'(sys_ready), 0);
      check("ar lost", 32'(lock_lost), 0);
      check("ar cnt", 32'(lock_loss_cnt), 0);
      tick(1);
      rst_n = 1'b1;
      check_powerup("ar pu");

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
